// File: rtl/ram_stream_reader.sv
// Sequential RAM read-out engine: walks an address range on a one-cycle registered-read
// RAM and streams the words over valid/ready through a 2-entry output buffer.
module ram_stream_reader #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned LEN_WIDTH = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_inflight;
    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_skid;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_ram_addr;

    logic       w_pop;
    logic       w_push;
    logic [2:0] w_level;
    logic       w_issue;
    logic [1:0] w_count_nxt;
    logic       w_drained;

    // Read-only engine: the write side of the RAM is tied off.
    assign ram_we    = 1'b0;
    assign ram_data  = '0;

    assign busy      = r_busy;
    assign done      = r_done;
    assign ram_addr  = r_ram_addr;
    assign out_data  = r_head;
    assign out_valid = r_out_valid;

    // Issue only if the word will have a buffer slot when it lands, counting this cycle's pop.
    assign w_pop       = r_out_valid & out_ready;
    assign w_push      = r_inflight;
    assign w_level     = 3'(r_count) + 3'(r_inflight);
    assign w_issue     = (r_state == S_READ) && (w_level < (3'(BUF_DEPTH) + 3'(w_pop)));
    assign w_count_nxt = 2'(r_count + 2'(w_push) - 2'(w_pop));
    assign w_drained   = !r_inflight && (w_count_nxt == 2'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_count     <= 2'd0;
            r_head      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ram_addr  <= '0;
        end else begin
            r_inflight  <= w_issue;
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != 2'd0);

            // Head register is the stream output; skid holds the second word.
            if (w_pop && (r_count == 2'd2)) begin
                r_head <= r_skid;
                if (w_push) begin
                    r_skid <= ram_out;
                end
            end else if (w_push && ((r_count == 2'd0) || w_pop)) begin
                r_head <= ram_out;
            end else if (w_push) begin
                r_skid <= ram_out;
            end

            if (w_issue) begin
                r_ram_addr  <= r_ram_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_READ;
                            r_busy      <= 1'b1;
                            r_ram_addr  <= base_addr;
                            r_remaining <= length;
                        end
                    end
                end
                S_READ: begin
                    if (w_issue && (r_remaining == LEN_WIDTH'(1))) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Leave on the edge of the final handshake so done follows immediately.
                    if (w_drained) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural RAM, expected-word scoreboard, directed transfers.
module tb_ram_stream_reader;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_out;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] sb [$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    ram_stream_reader dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_data  (ram_data),
        .ram_out   (ram_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + DW'(i);
    end

    // One-cycle registered-read RAM
    always @(posedge clock) ram_out <= mem[ram_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Handshakes are judged at the negedge preceding the edge where they occur.
    always @(negedge clock) begin
        if (!reset) begin
            check("ram_we", 32'(ram_we), 32'd0);
            check("ram_data", 32'(ram_data), 32'd0);
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                check("beat_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("beat_data", 32'(out_data), 32'(sb.pop_front()));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] l);
        logic [AW-1:0] a;
        start     = 1'b1;
        base_addr = b;
        length    = l;
        for (int i = 0; i < int'(l); i++) begin
            a = b + AW'(i);
            sb.push_back(8'hA0 + {4'h0, a});
        end
        @(posedge clock); #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'(l != 0));
        if (l != 0) check("ram_addr_base", 32'(ram_addr), 32'(b));
        else        check("done_len0", 32'(done), 32'd1);
    endtask

    task automatic wait_done(input bit bp, input bit poke, output int cyc, output int first_valid);
        cyc = 0;
        first_valid = -1;
        for (int k = 1; k <= 200; k++) begin
            out_ready = bp ? ((k % 3) == 1) : 1'b1;
            start = poke && (k == 3);
            if (start) begin
                base_addr = 4'd9;
                length    = 5'd3;
            end
            @(posedge clock); #1;
            start = 1'b0;
            if (out_valid && first_valid < 0) first_valid = k;
            if (done) begin
                cyc = k;
                break;
            end
            check("busy_hold", 32'(busy), 32'd1);
        end
        out_ready = 1'b1;
        check("done_seen", 32'(cyc != 0), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        @(posedge clock); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_data", 32'(ram_data), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int fv;
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_reset_values();
        reset = 1'b0;
        @(posedge clock); #1;

        // Basic transfer: A3..A6 back to back
        do_start(4'd3, 5'd4);
        wait_done(1'b0, 1'b0, cyc, fv);
        check("t1_first_valid", 32'(fv), 32'd2);
        check("t1_cycles", 32'(cyc), 32'd6);

        // Address wrap-around: AE, AF, A0, A1
        do_start(4'd14, 5'd4);
        wait_done(1'b0, 1'b0, cyc, fv);
        check("t2_first_valid", 32'(fv), 32'd2);
        check("t2_cycles", 32'(cyc), 32'd6);

        // Backpressure pattern 1,0,0,...
        do_start(4'd0, 5'd6);
        wait_done(1'b1, 1'b0, cyc, fv);

        // Zero-length transfer
        do_start(4'd0, 5'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_valid", 32'(out_valid), 32'd0);
        @(posedge clock); #1;
        check("t4_done_clear", 32'(done), 32'd0);
        check("t4_busy_after", 32'(busy), 32'd0);
        check("t4_valid_after", 32'(out_valid), 32'd0);

        // Reset after two beats of an 8-word transfer
        do_start(4'd0, 5'd8);
        repeat (4) begin
            @(posedge clock); #1;
        end
        check("t5_beats_before_reset", 32'(sb.size()), 32'd6);
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_values();
        sb.delete();
        reset = 1'b0;
        @(posedge clock); #1;
        check("t5_no_done", 32'(done), 32'd0);
        check("t5_idle_valid", 32'(out_valid), 32'd0);
        do_start(4'd5, 5'd2);
        wait_done(1'b0, 1'b0, cyc, fv);
        check("t5_cycles", 32'(cyc), 32'd4);

        // Full-range transfer with a start pulse while busy
        do_start(4'd0, 5'd16);
        wait_done(1'b0, 1'b1, cyc, fv);
        check("t6_cycles", 32'(cyc), 32'd18);
        @(posedge clock); #1;
        check("t6_no_restart", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
